// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the next-level memory responder.
//   state_t     : responder sequencing states (IDLE, WAIT, RESP)
//   req_t       : latched request {write, addr, wdata}
//   block_index : byte address -> block store index
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int unsigned ADDR_W     = 48;
  // Request data is carried at this fixed width; DATA_W must not exceed it.
  localparam int unsigned MAX_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W-1:0]     addr;
    logic [MAX_DATA_W-1:0] wdata;
  } req_t;

  // Block offset bits are discarded, then the block number wraps onto the
  // store depth, so distant addresses alias onto the same entry.
  function automatic logic [ADDR_W-1:0] block_index(
    input logic [ADDR_W-1:0] addr,
    input int unsigned       blocksize,
    input int unsigned       depth
  );
    block_index = (addr / ADDR_W'(blocksize)) % ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/mem_store.sv
// -----------------------------------------------------------------------------
// mem_store
// Single-port DEPTH x DATA_W block store: synchronous write, combinational
// read, synchronous active-low clear of every entry.
// Ports:
//   clk      : clock
//   reset    : synchronous active-low clear
//   i_we     : write enable
//   i_idx    : entry index (shared by read and write)
//   i_wdata  : write data
//   o_rdata  : read data of entry i_idx
// -----------------------------------------------------------------------------
module mem_store #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_idx,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Store array: whole-array clear on reset, single write port otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Next-level memory model below the cache. Accepts one block request at a
// time, waits LATENCY cycles, then presents a response until the cache takes
// it. Write-backs update the block store at the response handshake, so a
// following fill of the same block returns the new data. Completed fills and
// write-backs are counted (wrapping at 2^CNT_W).
//
// Optional build macro MEM_RESP_ERR_EN: adds parameter ADDR_LIMIT and output
// resp_err; requests at or above ADDR_LIMIT complete with resp_err=1,
// resp_rdata=0, no store write and no counter update.
//
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake
//   req_write/addr/wdata       : request (0 = fill read, 1 = write-back)
//   resp_valid/resp_ready      : response handshake
//   resp_write/rdata/addr      : response (echoes of the accepted request)
//   num_fills, num_writebacks  : completed read / write responses
//   busy                       : high whenever not IDLE
//   resp_err                   : out-of-range request (MEM_RESP_ERR_EN only)
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned BLOCKSIZE = 64,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned CNT_W     = 12
`ifdef MEM_RESP_ERR_EN
  ,
  parameter logic [47:0] ADDR_LIMIT = 48'(DEPTH * BLOCKSIZE)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [47:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [47:0]       resp_addr,
  output logic [CNT_W-1:0]  num_fills,
  output logic [CNT_W-1:0]  num_writebacks,
`ifdef MEM_RESP_ERR_EN
  output logic              resp_err,
`endif
  output logic              busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              r_state;
  req_t                r_req;
  logic [IDX_W-1:0]    r_idx;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_err;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_write;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic [47:0]         r_resp_addr;
  logic [CNT_W-1:0]    r_num_fills;
  logic [CNT_W-1:0]    r_num_wb;
  logic                r_busy;
`ifdef MEM_RESP_ERR_EN
  logic                r_resp_err;
`endif

  logic [ADDR_W-1:0]   w_idx_full;
  logic [IDX_W-1:0]    w_req_idx;
  logic                w_req_err;
  logic                w_we;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  assign w_idx_full = block_index(req_addr, BLOCKSIZE, DEPTH);
  assign w_req_idx  = w_idx_full[IDX_W-1:0];
`ifdef MEM_RESP_ERR_EN
  assign w_req_err  = (req_addr >= ADDR_LIMIT);
`else
  assign w_req_err  = 1'b0;
`endif

  // The write commits on the response handshake, before IDLE can accept again.
  assign w_we = (r_state == RESP) && resp_ready && r_req.write && !r_err;

  // Upper index bits and padding of the wide data field are intentionally dropped.
  assign w_unused = ^{w_idx_full, r_req.wdata};

  mem_store #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (r_req.wdata[DATA_W-1:0]),
    .o_rdata (w_rdata)
  );

  // Request/response sequencing, statistics and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_idx        <= '0;
      r_wait       <= '0;
      r_err        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_addr  <= 48'h0;
      r_num_fills  <= '0;
      r_num_wb     <= '0;
      r_busy       <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // req_ready is always high in IDLE, so req_valid alone means accept.
          if (req_valid) begin
            r_req       <= '{write: req_write, addr: req_addr,
                             wdata: MAX_DATA_W'(req_wdata)};
            r_idx       <= w_req_idx;
            r_err       <= w_req_err;
            r_wait      <= WAIT_W'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - 1'b1;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_write <= r_req.write;
            r_resp_addr  <= r_req.addr;
            r_resp_rdata <= (r_req.write || r_err) ? '0 : w_rdata;
`ifdef MEM_RESP_ERR_EN
            r_resp_err   <= r_err;
`endif
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (!r_err) begin
              if (r_req.write) begin
                r_num_wb <= r_num_wb + 1'b1;
              end else begin
                r_num_fills <= r_num_fills + 1'b1;
              end
            end
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_write     = r_resp_write;
  assign resp_rdata     = r_resp_rdata;
  assign resp_addr      = r_resp_addr;
  assign num_fills      = r_num_fills;
  assign num_writebacks = r_num_wb;
  assign busy           = r_busy;
`ifdef MEM_RESP_ERR_EN
  assign resp_err       = r_resp_err;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Scoreboard bench for mem_responder: each accepted request pushes its
// expected response (from a bench-side block store model); the entry is
// popped and compared when the DUT presents the response.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int unsigned LAT = 4;
  localparam int unsigned BS  = 64;
  localparam int unsigned DP  = 512;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 12;
`ifdef MEM_RESP_ERR_EN
  localparam logic [47:0] LIMIT = 48'h8000;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [47:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_write;
  logic [DW-1:0] resp_rdata;
  logic [47:0]   resp_addr;
  logic [CW-1:0] num_fills;
  logic [CW-1:0] num_writebacks;
  logic          busy;
`ifdef MEM_RESP_ERR_EN
  logic          resp_err;
`endif

  always #5 clk = ~clk;

  mem_responder #(
    .BLOCKSIZE (BS),
    .DEPTH     (DP),
    .DATA_W    (DW),
    .LATENCY   (LAT),
    .CNT_W     (CW)
`ifdef MEM_RESP_ERR_EN
    ,
    .ADDR_LIMIT(LIMIT)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_write     (resp_write),
    .resp_rdata     (resp_rdata),
    .resp_addr      (resp_addr),
    .num_fills      (num_fills),
    .num_writebacks (num_writebacks),
`ifdef MEM_RESP_ERR_EN
    .resp_err       (resp_err),
`endif
    .busy           (busy)
  );

  typedef struct {
    bit          w;
    logic [47:0] a;
    logic [31:0] d;
    bit          e;
  } exp_t;

  exp_t          sb[$];
  logic [31:0]   mdl[int];
  logic [CW-1:0] m_fills = '0;
  logic [CW-1:0] m_wbs   = '0;
  int            n_chk   = 0;
  int            n_pass  = 0;

  // Count one comparison, report it when observed differs from expected.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int idx_of(input logic [47:0] a);
    return int'((a / 48'(BS)) % 48'(DP));
  endfunction

  function automatic logic [31:0] mdl_rd(input int i);
    return mdl.exists(i) ? mdl[i] : 32'h0;
  endfunction

  // One full transaction; bp = cycles resp_ready is held low after resp_valid.
  task automatic transact(input bit w, input logic [47:0] a, input logic [31:0] d, input int bp);
    exp_t        e;
    int          n;
    logic        sw;
    logic [47:0] sa;
    logic [31:0] sd;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    e.w = w; e.a = a;
`ifdef MEM_RESP_ERR_EN
    e.e = (a >= LIMIT);
`else
    e.e = 1'b0;
`endif
    e.d = (w || e.e) ? 32'h0 : mdl_rd(idx_of(a));
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (n < 50) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (resp_valid) break;
    end
    chk("latency", 64'(n), 64'(LAT));
    sw = resp_write; sa = resp_addr; sd = resp_rdata;
    for (int i = 0; i < bp; i++) begin
      // A competing request during backpressure must be ignored.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 48'h40;
      @(negedge clk);
      chk("bp_valid", {63'd0, resp_valid}, 64'd1);
      chk("bp_write", {63'd0, resp_write}, {63'd0, sw});
      chk("bp_addr", 64'(resp_addr), 64'(sa));
      chk("bp_rdata", 64'(resp_rdata), 64'(sd));
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    e = sb.pop_front();
    chk("resp_write", {63'd0, resp_write}, {63'd0, e.w});
    chk("resp_addr", 64'(resp_addr), 64'(e.a));
    chk("resp_rdata", 64'(resp_rdata), 64'(e.d));
`ifdef MEM_RESP_ERR_EN
    chk("resp_err", {63'd0, resp_err}, {63'd0, e.e});
`endif
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    if (!e.e) begin
      if (w) begin mdl[idx_of(a)] = d; m_wbs++; end
      else m_fills++;
    end
    @(negedge clk);
    chk("resp_valid_low", {63'd0, resp_valid}, 64'd0);
    chk("req_ready_back", {63'd0, req_ready}, 64'd1);
    chk("busy_low", {63'd0, busy}, 64'd0);
    chk("num_fills", 64'(num_fills), 64'(m_fills));
    chk("num_writebacks", 64'(num_writebacks), 64'(m_wbs));
  endtask

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 48'h0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_write", {63'd0, resp_write}, 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_addr", 64'(resp_addr), 64'd0);
    chk("rst_fills", 64'(num_fills), 64'd0);
    chk("rst_wbs", 64'(num_writebacks), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
`ifdef MEM_RESP_ERR_EN
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
`endif

    // Read after reset, write/read-back, aliasing, untouched neighbour.
    transact(1'b0, 48'h1040, 32'h0, 0);
    transact(1'b1, 48'h2000, 32'hDEADBEEF, 0);
    transact(1'b0, 48'h2000, 32'h0, 0);
    transact(1'b1, 48'h0, 32'h11, 0);
    transact(1'b0, 48'h8000, 32'h0, 0);
    transact(1'b0, 48'h2040, 32'h0, 0);
    // Backpressure with a competing request held.
    transact(1'b0, 48'h2000, 32'h0, 10);

    // Reset two cycles into WAIT of a write: nothing completes, store cleared.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 48'h3000; req_wdata = 32'hCAFEF00D;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    mdl.delete(); m_fills = '0; m_wbs = '0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("no_resp_after_reset", 64'(n), 64'd0);
    chk("midrst_fills", 64'(num_fills), 64'd0);
    chk("midrst_wbs", 64'(num_writebacks), 64'd0);
    transact(1'b0, 48'h3000, 32'h0, 0);
    transact(1'b0, 48'h2000, 32'h0, 0);

`ifdef MEM_RESP_ERR_EN
    transact(1'b1, 48'h8000, 32'h55, 0);
    transact(1'b0, 48'h8000, 32'h0, 0);
    transact(1'b0, 48'h0, 32'h0, 0);
    transact(1'b1, 48'h7FC0, 32'h77, 0);
    transact(1'b0, 48'h7FC0, 32'h0, 0);
`endif

    // Fill counter wrap: top up to a multiple of 2^CNT_W completed reads.
    transact(1'b1, 48'h40, 32'h12345678, 0);
    n = 4096 - int'(m_fills);
    for (int i = 0; i < n; i++) begin
      transact(1'b0, 48'(i % 8) * 48'd64, 32'h0, 0);
    end
    chk("fill_wrap", 64'(num_fills), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Next-level memory model that answers the cache's miss-fill reads and write-back writes.
- Sits below the cache: accepts one block request at a time over a valid/ready handshake, waits a programmable latency, then returns a response over a second valid/ready handshake.
- Keeps a small block store so that written data is read back on later fills.
- Counts serviced fills and write-backs for miss and traffic statistics.

Parameters:
- BLOCKSIZE, 64: bytes per block; the low log2(BLOCKSIZE) address bits are the offset and are ignored.
- DEPTH, 512: number of blocks in the store. Must be a power of two.
- DATA_W, 32: width of the per-block data token.
- LATENCY, 4: cycles from request accept to response valid. Must be >= 1.
- CNT_W, 12: width of the statistics counters.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; asserted when 0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  0 = fill read, 1 = write-back.
- req_addr  input  48  byte address.
- req_wdata  input  DATA_W  write-back data.
- resp_valid  output  1  response present.
- resp_ready  input  1  cache accepts the response.
- resp_write  output  1  echo of req_write for the response.
- resp_rdata  output  DATA_W  fill data; 0 for write responses.
- resp_addr  output  48  echo of the accepted req_addr.
- num_fills  output  CNT_W  completed read responses.
- num_writebacks  output  CNT_W  completed write responses.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state goes to IDLE.
  - req_ready=1, resp_valid=0, resp_write=0, resp_rdata=0, resp_addr=0, num_fills=0, num_writebacks=0, busy=0.
  - All store entries are cleared to 0.
  - Reset mid-operation drops any outstanding request with no store update.
- Index = (addr / BLOCKSIZE) % DEPTH.
- State IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch write, addr, wdata and index; load the wait counter with LATENCY-1; go to WAIT.
- State WAIT:
  - req_ready=0.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, go to RESP. On that same edge:
    - resp_valid<=1, resp_write<=latched write, resp_addr<=latched addr.
    - resp_rdata<=store[index] for a read, 0 for a write.
- State RESP:
  - resp_valid stays 1; resp_* are stable until the handshake.
  - On resp_ready:
    - A write commits store[index]<=wdata.
    - The matching counter increments and wraps modulo 2^CNT_W.
    - resp_valid<=0; go to IDLE.
- Latency:
  - Accept edge to resp_valid high is exactly LATENCY cycles.
  - With resp_ready held high, back-to-back throughput is one request per LATENCY+2 cycles.
- Only one request is outstanding at a time. A write commits before the next accept, so a read to the same block returns the new data.
- resp_ready while resp_valid=0 is ignored.
- req_valid while req_ready=0 is ignored; the cache holds the request.
- Address bits above the index are not checked except when MEM_RESP_ERR_EN is defined.

Optional Feature:
- Macro MEM_RESP_ERR_EN.
- When defined:
  - Adds parameter ADDR_LIMIT (default DEPTH*BLOCKSIZE) and output resp_err (1 bit, reset 0).
  - A request with req_addr >= ADDR_LIMIT still completes the full latency.
  - Its response asserts resp_err=1 and returns resp_rdata=0.
  - It performs no store write.
  - It increments neither counter.
- When undefined: no resp_err port, and all addresses alias through the index.

Decomposition:
- Package mem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - a request struct {write, addr, wdata};
  - a helper function computing the index from addr, BLOCKSIZE and DEPTH.
- Natural sub-module: mem_store, a single-port DEPTH x DATA_W array.
  - Synchronous write, combinational read.
  - Synchronous active-low clear.

Test Plan:
- Reset then read:
  - Stimulus: hold reset=0 for 2 cycles; request write=0, addr=0x1040, LATENCY=4.
  - Response: resp_valid rises exactly 4 cycles after accept; resp_rdata=0; num_fills=1.
- Write then read back:
  - Stimulus: write addr=0x2000 wdata=0xDEADBEEF; then read addr=0x2000.
  - Response: read returns 0xDEADBEEF; num_writebacks=1, num_fills=1.
- Aliasing:
  - Stimulus: write 0x0 data 0x11; read 0x8000 (DEPTH=512, BLOCKSIZE=64).
  - Response: returns 0x11.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 10 cycles after resp_valid.
  - Response: resp_* stable throughout; req_ready=0; a second req_valid is not accepted until 1 cycle after the handshake.
- Reset mid-WAIT:
  - Stimulus: pulse reset=0 two cycles after accepting a write.
  - Response: no response issued; counters 0; a later read of that address returns 0.
- Counter wrap:
  - Stimulus: 4096 reads.
  - Response: num_fills=0.
- MEM_RESP_ERR_EN:
  - Stimulus: request addr=0x8000 with ADDR_LIMIT=0x8000.
  - Response: resp_err=1, counters unchanged.
